instr_mem_loader: RTL and testbench
===================================

# instr_mem_loader

Byte-serial program loader that fills the pipeline CPU's instruction memory in hardware, the write-side counterpart to the hex-file image read at simulation start. It accepts a little-endian byte stream over a valid/ready handshake, assembles 32-bit words, and issues word writes to the instruction memory. It holds the CPU in reset until the image is complete. It sits between an external host/byte source and the InstrMem write port, alongside the PipelineMIPS core.

## Interface
- BASE_ADDR, 32'h0000_0000: byte address of the first written word; must be word-aligned.
- MAX_WORDS, 256: instruction memory capacity in words.
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-low reset: sampled on rising clk, reset when 0.
- start  input  1  one-cycle request to begin a load; honoured only in IDLE or DONE.
- len_words  input  16  number of words to load, latched on accepted start.
- in_valid  input  1  byte source has data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  instruction-memory word write strobe.
- mem_addr  output  32  byte address of the write, word-aligned.
- mem_wdata  output  32  assembled word.
- cpu_hold  output  1  active-high; drives the CPU reset while loading.
- done  output  1  level; image fully written.
- err  output  1  level; checksum mismatch (see Configuration).

## Operation
- States: IDLE, RECV, WRITE, CHECK (macro only), DONE.
- IDLE/DONE + start: latch n = min(len_words, MAX_WORDS). Clear word count, byte index and sum; clear done/err.
  - n = 0: go to DONE (CHECK first if macro on).
  - n > 0: go to RECV.
- RECV: in_ready=1. Byte accepted on in_valid && in_ready. Byte k (0..3) goes to word bits [8k+7:8k], so the first byte is the LSB. The 4th accepted byte moves the FSM to WRITE.
- WRITE: mem_we=1 for exactly one cycle; in_ready=0.
  - mem_addr = BASE_ADDR + 4*word_count; mem_wdata = assembled word.
  - Then word_count++. If word_count reaches n, go to CHECK/DONE; otherwise go to RECV.
- DONE: done=1 until the next accepted start or reset.
- cpu_hold=1 in RECV, WRITE and CHECK; 0 in IDLE and DONE.
- start outside IDLE/DONE: ignored.
- in_valid while in_ready=0: ignored; the source must hold the byte.
- Reset mid-load: return to IDLE; the partial word is discarded and no write is issued.

## Timing
- Reset values: in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_hold=0, done=0, err=0.
- start in cycle t → RECV and in_ready=1 in cycle t+1.
- 4th byte accepted in cycle t → mem_we=1 in cycle t+1 → in_ready=1 again in cycle t+2.
- Peak throughput is one word per 5 cycles.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- done rises the cycle after the last WRITE (or after CHECK when the macro is on). cpu_hold falls in that same cycle.

## Configuration
- INSTR_LOADER_CHECKSUM_EN defined:
  - An 8-bit running sum (mod 256) accumulates every data byte.
  - After the last word, CHECK asserts in_ready and accepts one trailer byte.
  - err = ((sum + trailer) mod 256 != 0), latched on the transition into DONE.
  - For n=0, the trailer alone is checked.
- Not defined: no CHECK state, no sum register, err tied to 0.

## Structure
- Shared package holds the state encoding constants (IDLE, RECV, WRITE, CHECK, DONE) and WORD_BYTES=4.
- One sub-module, loader_word_asm: shift/assemble register with a byte index, load strobe, full flag and clear.
- The FSM, counters and checksum live in the top module.

## Test plan
- Reset with the macro off: start, len_words=2, bytes 20 00 08 00 / 24 00 09 00 (back-to-back valid).
  - Expect mem_we pulses with addr 0x0 data 0x00080020, then addr 0x4 data 0x00090024.
  - Expect done=1 and cpu_hold=0 the cycle after the second write.
- Gapped in_valid (one idle cycle between each byte), len_words=1, bytes 78 56 34 12: single write of 0x12345678. in_ready stays high through the gaps.
- rst=0 after 2 bytes of a word, then a fresh start with len_words=1 and bytes AA BB CC DD: no write before the reset; then exactly one write of 0xDDCCBBAA to BASE_ADDR.
- len_words=0: done=1 two cycles after start and no mem_we (macro off). len_words=300 with MAX_WORDS=256: exactly 256 writes, last mem_addr=0x3FC.
- Macro on, len_words=1, bytes 01 02 03 04 and trailer F6: err=0. Same stream with trailer F7: err=1, done=1.
- start asserted during RECV: ignored, and word count and addresses are unchanged.

Source files
------------

// File: rtl/instr_mem_loader_pkg.sv
// Shared loader types: FSM state encoding, bytes-per-word, and the length clamp.
// Purely declarative, so it adds no latency and no backpressure.
package instr_mem_loader_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic logic [15:0] clamp_len(input logic [15:0] len,
                                            input int unsigned max_words);
    logic [31:0] max_w;
    max_w = max_words;
    return ({16'h0, len} > max_w) ? max_w[15:0] : len;
  endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Byte-stream input (valid/ready) and instruction-memory word-write port of the loader.
// slave = loader side, master = host/testbench side; the host holds its byte while in_ready is 0.
interface instr_mem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport slave  (input  in_valid, in_data, output in_ready, mem_we, mem_addr, mem_wdata);
  modport master (output in_valid, in_data, input  in_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/instr_mem_loader_word_asm.sv
// Little-endian byte-to-word assembler; word_nxt is the word including the byte being loaded.
// full flags the load that completes a word; no backpressure of its own (the parent gates load).
module loader_word_asm
  import instr_mem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        load,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_nxt,
  output logic        full
);

  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;

  always_comb begin
    word_nxt = word_q;
    word_nxt[8*idx_q +: 8] = byte_in;
    full   = load && (idx_q == 2'(WORD_BYTES - 1));
    idx_d  = idx_q;
    word_d = word_q;
    if (clr) begin
      idx_d  = 2'd0;
      word_d = '0;
    end else if (load) begin
      // index wraps to 0 after the last byte, ready for the next word
      idx_d  = idx_q + 2'd1;
      word_d = full ? '0 : word_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      idx_q  <= 2'd0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Byte-serial instruction-memory loader: start->RECV in 1 cycle, 4th byte->mem_we next cycle (5 cycles/word).
// in_ready only in RECV (and CHECK); optional trailer checksum under INSTR_LOADER_CHECKSUM_EN.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [15:0]         len_words,
  instr_mem_loader_if.slave   bus,
  output logic                cpu_hold,
  output logic                done,
  output logic                err
);

  state_e      state_q, state_d;
  logic [15:0] n_q, n_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] n_start;
  logic        in_ready_c, accept;
  logic        asm_clr, asm_load, asm_full;
  logic [31:0] asm_word;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]  sum_q, sum_d;
  logic        err_q, err_d;
  localparam state_e ST_END = ST_CHECK;
`else
  localparam state_e ST_END = ST_DONE;
`endif

  loader_word_asm u_word_asm (
    .clk      (clk),
    .rst      (rst),
    .clr      (asm_clr),
    .load     (asm_load),
    .byte_in  (bus.in_data),
    .word_nxt (asm_word),
    .full     (asm_full)
  );

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    asm_clr  = 1'b0;
    n_start  = clamp_len(len_words, MAX_WORDS);
`ifdef INSTR_LOADER_CHECKSUM_EN
    sum_d      = sum_q;
    err_d      = err_q;
    in_ready_c = (state_q == ST_RECV) || (state_q == ST_CHECK);
`else
    in_ready_c = (state_q == ST_RECV);
`endif
    accept   = bus.in_valid && in_ready_c;
    asm_load = accept && (state_q == ST_RECV);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          n_d     = n_start;
          cnt_d   = '0;
          asm_clr = 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
          sum_d   = '0;
          err_d   = 1'b0;
`endif
          state_d = (n_start == 16'd0) ? ST_END : ST_RECV;
        end
      end
      ST_RECV: begin
`ifdef INSTR_LOADER_CHECKSUM_EN
        if (accept) sum_d = sum_q + bus.in_data;
`endif
        // capture address and data now so they stay stable after the write
        if (asm_full) begin
          addr_d  = BASE_ADDR + {14'h0, cnt_q, 2'b00};
          wdata_d = asm_word;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        cnt_d   = cnt_q + 16'd1;
        state_d = (cnt_q + 16'd1 == n_q) ? ST_END : ST_RECV;
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (accept) begin
          err_d   = ((sum_q + bus.in_data) != 8'd0);
          state_d = ST_DONE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      cnt_q   <= '0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      sum_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.mem_we    = (state_q == ST_WRITE);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign cpu_hold      = (state_q == ST_RECV) || (state_q == ST_WRITE) || (state_q == ST_CHECK);
  assign done          = (state_q == ST_DONE);
`ifdef INSTR_LOADER_CHECKSUM_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: inputs driven and outputs sampled on the falling edge.
// Writes are logged on the rising edge; checksum steps run only with INSTR_LOADER_CHECKSUM_EN.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] len_words = '0;
  logic        cpu_hold, done, err;

  int          vectors = 0;
  int          fails = 0;
  int          wr_cnt = 0;
  int          wr_base = 0;
  logic [7:0]  run_sum = '0;

  instr_mem_loader_if bus ();

  instr_mem_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(256)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len_words (len_words),
    .bus       (bus),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst && bus.mem_we) wr_cnt <= wr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [15:0] len);
    start     = 1'b1;
    len_words = len;
    @(negedge clk);
    start     = 1'b0;
    run_sum   = '0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int budget = 50;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!bus.in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      fails++;
      $error("FAIL in_ready_timeout: observed 0 expected 1");
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    run_sum = run_sum + b;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic chk_write(input string tag, input logic [31:0] a, input logic [31:0] d);
    chk({tag, "_we"},   bus.mem_we,    1);
    chk({tag, "_addr"}, bus.mem_addr,  a);
    chk({tag, "_data"}, bus.mem_wdata, d);
  endtask

  // Completes an image from WRITE (last word) or CHECK; ends on the first DONE cycle.
  task automatic finish_image();
`ifdef INSTR_LOADER_CHECKSUM_EN
    send_byte(8'h00 - run_sum);
`else
    @(negedge clk);
`endif
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_in_ready", bus.in_ready,  0);
    chk("rst_mem_we",   bus.mem_we,    0);
    chk("rst_mem_addr", bus.mem_addr,  32'h0);
    chk("rst_wdata",    bus.mem_wdata, 32'h0);
    chk("rst_cpu_hold", cpu_hold,      0);
    chk("rst_done",     done,          0);
    chk("rst_err",      err,           0);
    rst = 1'b1;
    @(negedge clk);

    // two words, back-to-back bytes
    wr_base = wr_cnt;
    do_start(16'd2);
    chk("t1_in_ready", bus.in_ready, 1);
    chk("t1_cpu_hold", cpu_hold,     1);
    send_word(32'h0008_0020);
    chk_write("t1_w0", 32'h0, 32'h0008_0020);
    chk("t1_w0_in_ready", bus.in_ready, 0);
    send_word(32'h0009_0024);
    chk_write("t1_w1", 32'h4, 32'h0009_0024);
    finish_image();
    chk("t1_done",      done,         1);
    chk("t1_cpu_hold0", cpu_hold,     0);
    chk("t1_we_low",    bus.mem_we,   0);
    chk("t1_addr_hold", bus.mem_addr, 32'h4);
    chk("t1_wr_count",  wr_cnt - wr_base, 2);

    // gapped bytes, restart from DONE
    wr_base = wr_cnt;
    do_start(16'd1);
    chk("t2_done_clr", done, 0);
    send_byte(8'h78); chk("t2_gap0_rdy", bus.in_ready, 1); @(negedge clk);
    send_byte(8'h56); chk("t2_gap1_rdy", bus.in_ready, 1); @(negedge clk);
    send_byte(8'h34); chk("t2_gap2_rdy", bus.in_ready, 1); @(negedge clk);
    send_byte(8'h12);
    chk_write("t2_w0", 32'h0, 32'h1234_5678);
    finish_image();
    chk("t2_done",     done, 1);
    chk("t2_wr_count", wr_cnt - wr_base, 1);

    // reset in the middle of a word
    wr_base = wr_cnt;
    do_start(16'd1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("t3_rst_wr",       wr_cnt - wr_base, 0);
    chk("t3_rst_hold",     cpu_hold,     0);
    chk("t3_rst_in_ready", bus.in_ready, 0);
    chk("t3_rst_done",     done,         0);
    rst = 1'b1;
    @(negedge clk);
    do_start(16'd1);
    send_word(32'hDDCC_BBAA);
    chk_write("t3_w0", 32'h0, 32'hDDCC_BBAA);
    finish_image();
    chk("t3_done",     done, 1);
    chk("t3_wr_count", wr_cnt - wr_base, 1);

    // start during RECV is ignored
    wr_base = wr_cnt;
    do_start(16'd2);
    send_word(32'h4433_2211);
    chk_write("t4_w0", 32'h0, 32'h4433_2211);
    @(negedge clk);
    start = 1'b1; len_words = 16'd1;
    @(negedge clk);
    start = 1'b0;
    chk("t4_still_recv", bus.in_ready, 1);
    chk("t4_still_hold", cpu_hold,     1);
    send_word(32'h8877_6655);
    chk_write("t4_w1", 32'h4, 32'h8877_6655);
    finish_image();
    chk("t4_done",     done, 1);
    chk("t4_wr_count", wr_cnt - wr_base, 2);

    // zero-length image
    wr_base = wr_cnt;
    do_start(16'd0);
    finish_image();
    chk("t5_done",     done,     1);
    chk("t5_cpu_hold", cpu_hold, 0);
    chk("t5_wr_count", wr_cnt - wr_base, 0);

    // len_words above capacity clamps to 256 words
    wr_base = wr_cnt;
    do_start(16'd300);
    for (int w = 0; w < 256; w++) begin
      for (int k = 0; k < 4; k++) send_byte(8'(4 * w + k));
    end
    chk_write("t6_last", 32'h3FC, 32'hFFFE_FDFC);
    finish_image();
    chk("t6_done",     done, 1);
    chk("t6_wr_count", wr_cnt - wr_base, 256);
    chk("t6_addr_hold", bus.mem_addr, 32'h3FC);

`ifdef INSTR_LOADER_CHECKSUM_EN
    do_start(16'd1);
    send_word(32'h0403_0201);
    send_byte(8'hF6);
    chk("t7_good_done", done, 1);
    chk("t7_good_err",  err,  0);
    do_start(16'd1);
    chk("t7_err_clr", err, 0);
    send_word(32'h0403_0201);
    send_byte(8'hF7);
    chk("t7_bad_done", done, 1);
    chk("t7_bad_err",  err,  1);
`else
    chk("t7_err_tied", err, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
